// File: rtl/io_cond_pkg.sv
// Shared defaults and sizing helper for the board input conditioner.
package io_cond_pkg;
  localparam int SW_WIDTH_DEF  = 32;
  localparam int BTN_WIDTH_DEF = 4;
  localparam int TICK_DIV_DEF  = 50000;
  localparam int SAMPLES_DEF   = 4;

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/debounce_bit.sv
// One input bit: polarity fix, flop synchronizer, tick-sampled debounce counter.
module debounce_bit
  import io_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SAMPLES     = 4,
  parameter bit INVERT      = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_raw,
  input  logic i_tick,
  output logic o_stable,
  output logic o_upd
);
  localparam int CW = cnt_width(SAMPLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   syn;
  logic                   stable_q, stable_d;
  logic [CW-1:0]          cnt_q, cnt_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], i_raw ^ INVERT};
  end

  assign syn = sync_q[SYNC_STAGES-1];

  // Any cycle back at the stable level restarts the count, glitches included.
  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    o_upd    = 1'b0;
    if (syn == stable_q) begin
      cnt_d = '0;
    end else if (i_tick) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = syn;
        cnt_d    = '0;
        o_upd    = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign o_stable = stable_q;
endmodule

// File: rtl/io_input_cond.sv
// Switch/button conditioner: shared sample tick, per-bit debouncers, edge pulses.
module io_input_cond
  import io_cond_pkg::*;
#(
  parameter int SW_WIDTH       = SW_WIDTH_DEF,
  parameter int BTN_WIDTH      = BTN_WIDTH_DEF,
  parameter int SYNC_STAGES    = 2,
  parameter int TICK_DIV       = TICK_DIV_DEF,
  parameter int SAMPLES        = SAMPLES_DEF,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [SW_WIDTH-1:0]  i_sw_raw,
  input  logic [BTN_WIDTH-1:0] i_btn_raw,
  output logic [SW_WIDTH-1:0]  o_io_sw,
  output logic [BTN_WIDTH-1:0] o_io_btn,
  output logic [BTN_WIDTH-1:0] o_btn_press,
  output logic [BTN_WIDTH-1:0] o_btn_release,
  output logic                 o_sw_chg,
  output logic                 o_tick
);
  localparam int TW = cnt_width(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic                 tick;
  logic [SW_WIDTH-1:0]  sw_stable, sw_upd;
  logic [BTN_WIDTH-1:0] btn_stable, btn_upd;
  logic [BTN_WIDTH-1:0] press_q, release_q;
  logic                 chg_q;

  // Tick is masked in reset so TICK_DIV=1 still shows 0 on o_tick there.
  assign tick       = (tick_cnt_q == TICK_LAST) && !i_rst;
  assign tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tick_cnt_q <= '0;
    else       tick_cnt_q <= tick_cnt_d;
  end

  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_sw
    debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .SAMPLES    (SAMPLES),
      .INVERT     (1'b0)
    ) u_db (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_raw   (i_sw_raw[g]),
      .i_tick  (tick),
      .o_stable(sw_stable[g]),
      .o_upd   (sw_upd[g])
    );
  end

  for (genvar g = 0; g < BTN_WIDTH; g++) begin : g_btn
    debounce_bit #(
      .SYNC_STAGES(SYNC_STAGES),
      .SAMPLES    (SAMPLES),
      .INVERT     (BTN_ACTIVE_LOW)
    ) u_db (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_raw   (i_btn_raw[g]),
      .i_tick  (tick),
      .o_stable(btn_stable[g]),
      .o_upd   (btn_upd[g])
    );
  end

  // Pulses register alongside the stable flop, so they coincide with the new level.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      press_q   <= '0;
      release_q <= '0;
      chg_q     <= 1'b0;
    end else begin
      press_q   <= btn_upd & ~btn_stable;
      release_q <= btn_upd & btn_stable;
      chg_q     <= |sw_upd;
    end
  end

  assign o_io_sw       = sw_stable;
  assign o_io_btn      = btn_stable;
  assign o_btn_press   = press_q;
  assign o_btn_release = release_q;
  assign o_sw_chg      = chg_q;
  assign o_tick        = tick;
endmodule

// File: tb/tb_io_input_cond.sv
// Randomized + directed bench for io_input_cond with a window-based reference model.
module tb_io_input_cond;
  localparam int SW  = 32;
  localparam int BN  = 4;
  localparam int NB  = SW + BN;
  localparam int SS  = 2;
  localparam int TD  = 4;
  localparam int SP  = 3;
  localparam int WIN = (SP - 1) * TD + 1;

  typedef struct packed {
    logic [SW-1:0] sw;
    logic [BN-1:0] btn;
    logic [BN-1:0] press;
    logic [BN-1:0] rel;
    logic          chg;
    logic          tick;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [SW-1:0] sw_raw = 32'hDEADBEEF;
  logic [BN-1:0] btn_raw = 4'hF;
  logic [SW-1:0] o_io_sw;
  logic [BN-1:0] o_io_btn, o_btn_press, o_btn_release;
  logic          o_sw_chg, o_tick;

  int n_cmp = 0, n_err = 0;
  int chg_cnt = 0, press_cnt = 0, rel_cnt = 0;

  io_input_cond #(
    .SW_WIDTH(SW), .BTN_WIDTH(BN), .SYNC_STAGES(SS),
    .TICK_DIV(TD), .SAMPLES(SP), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_sw_raw(sw_raw), .i_btn_raw(btn_raw),
    .o_io_sw(o_io_sw), .o_io_btn(o_io_btn), .o_btn_press(o_btn_press),
    .o_btn_release(o_btn_release), .o_sw_chg(o_sw_chg), .o_tick(o_tick)
  );

  always #5 clk = ~clk;

  // Reference: a level is accepted at a tick when the synchronized input has
  // differed from it on every one of the last WIN cycles (SAMPLES ticks span).
  exp_t           expq[$];
  logic [NB-1:0]  rawq[$];
  logic [NB-1:0]  hist[$];
  logic [NB-1:0]  m_stable = '0;
  int             ecnt = 0;

  always @(posedge clk) begin
    logic [NB-1:0] syn, flip, nxt;
    exp_t          e;
    bit            tk, all;
    e = '0;
    if (rst) begin
      rawq.delete();
      hist.delete();
      m_stable = '0;
      ecnt     = 0;
    end else begin
      rawq.push_back({~btn_raw, sw_raw});
      syn = (rawq.size() > SS) ? rawq[rawq.size() - 1 - SS] : '0;
      if (rawq.size() > SS + 1) void'(rawq.pop_front());
      hist.push_back(syn);
      if (hist.size() > WIN) void'(hist.pop_front());
      tk = (ecnt % TD) == TD - 1;
      ecnt++;
      flip = '0;
      if (tk && hist.size() == WIN) begin
        for (int b = 0; b < NB; b++) begin
          all = 1'b1;
          for (int k = 0; k < WIN; k++)
            if (hist[k][b] == m_stable[b]) all = 1'b0;
          flip[b] = all;
        end
      end
      nxt     = m_stable ^ flip;
      e.sw    = nxt[SW-1:0];
      e.btn   = nxt[NB-1:SW];
      e.press = flip[NB-1:SW] & nxt[NB-1:SW];
      e.rel   = flip[NB-1:SW] & ~nxt[NB-1:SW];
      e.chg   = |flip[SW-1:0];
      e.tick  = (ecnt % TD) == TD - 1;
      m_stable = nxt;
    end
    expq.push_back(e);
  end

  // Monitor: one expected record per edge, checked half a cycle later.
  always @(negedge clk) begin
    exp_t e, a;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      if (rst) e = '0;
      a = '{sw: o_io_sw, btn: o_io_btn, press: o_btn_press, rel: o_btn_release,
            chg: o_sw_chg, tick: o_tick};
      n_cmp++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs t=%0t got sw=%h btn=%h pr=%h rl=%h chg=%b tk=%b want sw=%h btn=%h pr=%h rl=%h chg=%b tk=%b",
                 $time, a.sw, a.btn, a.press, a.rel, a.chg, a.tick,
                 e.sw, e.btn, e.press, e.rel, e.chg, e.tick);
      end
    end
    chg_cnt   += int'(o_sw_chg);
    press_cnt += $countones(o_btn_press);
    rel_cnt   += $countones(o_btn_release);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic clr();
    chg_cnt = 0; press_cnt = 0; rel_cnt = 0;
  endtask

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s got %h want %h", nm, a, e);
    end
  endtask

  initial begin
    // reset hold with switches pre-set
    cyc(3);
    chk("rst_outputs", {o_io_sw[3:0], o_io_btn, o_btn_press, o_btn_release, 6'(o_sw_chg)}, 32'h0);
    clr();
    rst = 1'b0;
    cyc(20);
    chk("rst_sw", o_io_sw, 32'hDEADBEEF);
    chk("rst_chg_cnt", chg_cnt, 1);
    chk("rst_btn", 32'(o_io_btn), 0);

    // clean press then release of button 2
    clr();
    btn_raw[2] = 1'b0;
    cyc(20);
    chk("press_btn", 32'(o_io_btn), 32'h4);
    chk("press_cnt", press_cnt, 1);
    chk("press_rel_cnt", rel_cnt, 0);
    btn_raw[2] = 1'b1;
    cyc(20);

    // bounce rejection on button 0
    clr();
    for (int i = 0; i < 10; i++) begin
      btn_raw[0] = ~btn_raw[0];
      cyc(3);
    end
    btn_raw[0] = 1'b1;
    cyc(20);
    chk("bounce_btn", 32'(o_io_btn), 0);
    chk("bounce_pulses", press_cnt + rel_cnt, 0);

    // multi-bit switch change
    sw_raw = 32'h0;
    cyc(20);
    clr();
    sw_raw = 32'h0000_00A5;
    cyc(20);
    chk("swchg_sw", o_io_sw, 32'h0000_00A5);
    chk("swchg_cnt", chg_cnt, 1);

    // release path on button 1
    btn_raw[1] = 1'b0;
    cyc(20);
    clr();
    btn_raw[1] = 1'b1;
    cyc(20);
    chk("release_cnt", rel_cnt, 1);
    chk("release_btn", 32'(o_io_btn), 0);

    // reset in the middle of a button 3 press
    clr();
    btn_raw[3] = 1'b0;
    cyc(6);
    rst = 1'b1;
    cyc(2);
    chk("midrst_outputs", {o_io_sw[7:0], o_io_btn, 20'(o_btn_press)}, 32'h0);
    rst = 1'b0;
    cyc(10);
    chk("midrst_early", 32'(o_io_btn), 0);
    cyc(10);
    chk("midrst_late", 32'(o_io_btn), 32'h8);
    chk("midrst_press_cnt", press_cnt, 1);

    // randomized phase: mixed holds and short glitches
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) sw_raw = $urandom;
      else sw_raw[$urandom_range(0, SW - 1)] ^= 1'b1;
      btn_raw = 4'($urandom);
      cyc($urandom_range(1, 16));
    end
    cyc(25);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/io_input_cond.md
Name: io_input_cond

Overview:
- Input conditioner that sits directly upstream of the single-cycle core's input-peripheral port.
- Takes raw asynchronous board switches and push-buttons and synchronizes them to i_clk.
- Debounces them with a shared sample tick, then drives the clean levels into the core's i_io_sw / i_io_btn.
- Also produces one-cycle press/release/change pulses for future interrupt or LSU status use.

Parameters:
- SW_WIDTH, 32: number of switch inputs.
- BTN_WIDTH, 4: number of button inputs.
- SYNC_STAGES, 2: flip-flop synchronizer depth per bit; minimum 2.
- TICK_DIV, 50000: i_clk cycles per debounce sample tick (1 ms at 50 MHz); minimum 1.
- SAMPLES, 4: consecutive mismatching ticks required to accept a new level; minimum 1.
- BTN_ACTIVE_LOW, 1: 1 = raw buttons read 0 when pressed. Outputs are always active-high.

Ports:
- i_clk, input, 1: system clock.
- i_rst, input, 1: asynchronous active-high reset.
- i_sw_raw, input, SW_WIDTH: raw switch pins, asynchronous.
- i_btn_raw, input, BTN_WIDTH: raw button pins, asynchronous.
- o_io_sw, output, SW_WIDTH: debounced switch levels, fed to core i_io_sw.
- o_io_btn, output, BTN_WIDTH: debounced button levels, 1 = pressed, fed to core i_io_btn.
- o_btn_press, output, BTN_WIDTH: one-cycle pulse per button on release→press.
- o_btn_release, output, BTN_WIDTH: one-cycle pulse per button on press→release.
- o_sw_chg, output, 1: one-cycle pulse when any o_io_sw bit changes.
- o_tick, output, 1: debug copy of the internal sample tick.

Behaviour:
Clock and reset (already decided):
- One clock, i_clk.
- Reset i_rst is asynchronous and active-high.
- While i_rst is high, all state is cleared:
  - synchronizer flops = inactive level (0 for switches, released for buttons after polarity);
  - stable levels = 0;
  - per-bit counters = 0;
  - tick counter = 0.
- All outputs are 0 during reset and on the first edge after deassertion.
- Reset asserted mid-debounce discards the partial count; no pulse is emitted for it.

Polarity:
- When BTN_ACTIVE_LOW=1, button raw bits are inverted before the synchronizer.
- All logic after the synchronizer is active-high.

Synchronizer:
- Each bit passes through a SYNC_STAGES flop chain.
- The last stage is "syn".

Tick generator:
- tick_cnt counts 0..TICK_DIV-1 and wraps.
- tick = 1 for exactly one cycle when tick_cnt == TICK_DIV-1.
- TICK_DIV=1 gives tick every cycle.

Per-bit debounce (identical for every switch and button bit):
- syn == stable on any cycle, tick or not → cnt cleared to 0. Any return to the stable level, even a one-cycle glitch, restarts the count.
- syn != stable, tick=1, cnt < SAMPLES-1 → cnt <= cnt+1.
- syn != stable, tick=1, cnt == SAMPLES-1 → stable <= syn, cnt <= 0.
- syn != stable, tick=0 → cnt holds.
- cnt width = clog2(SAMPLES) with a minimum of 1. cnt never exceeds SAMPLES-1.

Outputs:
- o_io_sw and o_io_btn are the stable registers directly.
- o_btn_press[i] and o_btn_release[i] are registered. They are high in the same cycle o_io_btn[i] first shows the new value, and low the next cycle.
- o_sw_chg is registered with the same timing: OR of all switch-bit updates in that cycle.
- Simultaneous updates of several bits on one tick are all reflected in that cycle. o_sw_chg is still a single pulse.
- o_tick equals tick.

Latency, from raw change (held steady) to output change:
- Minimum: SYNC_STAGES + (SAMPLES-1)*TICK_DIV + 1 cycles.
- Maximum: SYNC_STAGES + SAMPLES*TICK_DIV cycles.

Reset-release corner:
- Switches that are high at reset release debounce up to 1 after the normal latency.
- Each such update raises o_sw_chg once. This is intended: software sees the initial state as a change.

Decomposition:
- Package io_cond_pkg holds:
  - default constants SW_WIDTH_DEF, BTN_WIDTH_DEF, TICK_DIV_DEF, SAMPLES_DEF;
  - function cnt_width(n), returning clog2 with a minimum of 1.
- Sub-module debounce_bit, one per input bit, generated SW_WIDTH+BTN_WIDTH times:
  - contains synchronizer, counter, stable register and update strobe;
  - takes the shared tick as an input.
- Tick generator and pulse registers stay in io_input_cond.

Test Plan (bench parameters TICK_DIV=4, SAMPLES=3, SYNC_STAGES=2, BTN_ACTIVE_LOW=1):
- Reset hold: i_rst=1 for 3 cycles with i_sw_raw=32'hDEADBEEF, i_btn_raw=4'hF. All outputs stay 0 throughout reset. After release, o_io_sw == 32'hDEADBEEF within 2+12=14 cycles, with exactly one o_sw_chg pulse. o_io_btn stays 0.
- Clean press: i_btn_raw[2] 1→0, held 20 cycles. o_io_btn becomes 4'b0100 between cycles 11 and 14 after the edge. o_btn_press == 4'b0100 for exactly that one cycle; o_btn_release stays 0.
- Bounce rejection: i_btn_raw[0] toggles every 3 cycles for 30 cycles, then returns to 1. o_io_btn[0] stays 0 and no press/release pulse occurs.
- Switch change: i_sw_raw 32'h0 → 32'h0000_00A5 in one cycle. All 4 bits update in the same cycle. o_sw_chg is a single one-cycle pulse and o_io_sw == 32'h0000_00A5.
- Release path: hold button 1 pressed until debounced, then release. o_btn_release == 4'b0010 for one cycle and o_io_btn[1] returns to 0.
- Reset mid-debounce: start a press on button 3, assert i_rst 6 cycles after the raw edge while raw stays pressed. All outputs are 0 immediately, no pulse is emitted, and after release the debounce restarts from cnt=0 with full latency.
